gobou_seq: RTL and testbench

Layer sequencer for the gobou fully-connected engine and its ninjin DDR buffer. Holds a small descriptor table of up to MAXLAYER layers, one entry per layer, written by the host. On `start` it runs the layers back-to-back: for each layer it prefetches via ninjin, then fires gobou, then waits for completion. It also owns the image-memory ownership flag (`host_sel`) that the top level uses to mux the memory between host and gobou.

---
 rtl/gobou_seq_pkg.sv | 43 ++++
 rtl/gobou_seq_if.sv | 30 +++
 rtl/gobou_seq_desc.sv | 41 ++++
 rtl/gobou_seq.sv | 144 ++++++++++++++
 tb/tb_gobou_seq.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gobou_seq_pkg.sv
// Shared types and sizes for the gobou layer sequencer.
// Engine and buffer widths are mirrored here so the sequencer builds standalone.
package gobou_seq_pkg;

    localparam int unsigned MAXLAYER      = 4;
    localparam int unsigned LAYERLOG      = 2;
    localparam int unsigned IMGSIZE       = 16;
    localparam int unsigned GOBOU_NETSIZE = 14;
    localparam int unsigned LWIDTH        = 12;
    localparam int unsigned RATELOG       = 4;
    localparam int unsigned MEMSIZE       = IMGSIZE - RATELOG;
    localparam int unsigned GOBOU_CORE    = 16;
    localparam int unsigned FIELDW        = 3;

    localparam logic [FIELDW-1:0] SEQ_F_IN   = 3'd0;
    localparam logic [FIELDW-1:0] SEQ_F_OUT  = 3'd1;
    localparam logic [FIELDW-1:0] SEQ_F_NET  = 3'd2;
    localparam logic [FIELDW-1:0] SEQ_F_TIN  = 3'd3;
    localparam logic [FIELDW-1:0] SEQ_F_TOUT = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_PRE,
        S_PRE_LO,
        S_PRE_HI,
        S_RUN,
        S_RUN_LO,
        S_RUN_HI,
        S_NEXT,
        S_FIN
    } gobou_seq_state;

    // One layer descriptor as stored in the table.
    typedef struct packed {
        logic [IMGSIZE-1:0]       in_offset;
        logic [IMGSIZE-1:0]       out_offset;
        logic [GOBOU_NETSIZE-1:0] net_offset;
        logic [LWIDTH-1:0]        total_in;
        logic [LWIDTH-1:0]        total_out;
    } seq_desc_t;

endpackage

// File: rtl/gobou_seq_if.sv
// Handshake and parameter bus between the sequencer and the gobou engine / ninjin buffer.
interface gobou_seq_if;
    import gobou_seq_pkg::*;

    logic                     req;
    logic                     ack;
    logic [IMGSIZE-1:0]       in_offset;
    logic [IMGSIZE-1:0]       out_offset;
    logic [GOBOU_NETSIZE-1:0] net_offset;
    logic [LWIDTH-1:0]        total_in;
    logic [LWIDTH-1:0]        total_out;
    logic                     pre_req;
    logic                     pre_ack;
    logic [MEMSIZE-1:0]       pre_base;
    logic [LWIDTH-1:0]        read_len;
    logic [LWIDTH-1:0]        write_len;

    modport master (
        output req, in_offset, out_offset, net_offset, total_in, total_out,
        output pre_req, pre_base, read_len, write_len,
        input  ack, pre_ack
    );

    modport slave (
        input  req, in_offset, out_offset, net_offset, total_in, total_out,
        input  pre_req, pre_base, read_len, write_len,
        output ack, pre_ack
    );

endinterface

// File: rtl/gobou_seq_desc.sv
// Layer descriptor register file: host-written fields, combinational read by layer index.
module gobou_seq_desc
    import gobou_seq_pkg::*;
(
    input  logic                clk,
    input  logic                xrst,
    input  logic                we,
    input  logic                lock,
    input  logic [LAYERLOG-1:0] wlayer,
    input  logic [FIELDW-1:0]   field,
    input  logic [31:0]         wdata,
    input  logic [LAYERLOG-1:0] rlayer,
    output seq_desc_t           rdata
);

    seq_desc_t tbl [MAXLAYER];

    // Upper write-data bits beyond the widest field are deliberately discarded.
    logic unused_hi;
    assign unused_hi = ^wdata[31:IMGSIZE];

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int unsigned i = 0; i < MAXLAYER; i++) begin
                tbl[i] <= '0;
            end
        end else if (we && !lock) begin
            case (field)
                SEQ_F_IN:   tbl[wlayer].in_offset  <= IMGSIZE'(wdata);
                SEQ_F_OUT:  tbl[wlayer].out_offset <= IMGSIZE'(wdata);
                SEQ_F_NET:  tbl[wlayer].net_offset <= GOBOU_NETSIZE'(wdata);
                SEQ_F_TIN:  tbl[wlayer].total_in   <= LWIDTH'(wdata);
                SEQ_F_TOUT: tbl[wlayer].total_out  <= LWIDTH'(wdata);
                default: ;
            endcase
        end
    end

    assign rdata = tbl[rlayer];

endmodule

// File: rtl/gobou_seq.sv
// Layer sequencer: walks the descriptor table, prefetching via ninjin then firing gobou per layer.
// Also owns the image-memory ownership flag handed to the top-level mux.
module gobou_seq
    import gobou_seq_pkg::*;
(
    input  logic                clk,
    input  logic                xrst,
    input  logic                cfg_we,
    input  logic [LAYERLOG-1:0] cfg_layer,
    input  logic [FIELDW-1:0]   cfg_field,
    input  logic [31:0]         cfg_wdata,
    input  logic                start,
    input  logic [LAYERLOG:0]   n_layer,
    output logic                busy,
    output logic                done,
    output logic [LAYERLOG-1:0] cur_layer,
    output logic                host_sel,
    gobou_seq_if.master         bus
);

    localparam int unsigned CNTW = LAYERLOG + 1;

    gobou_seq_state      state_q;
    gobou_seq_state      state_d;
    logic [LAYERLOG-1:0] layer_q;
    logic [CNTW-1:0]     n_eff_q;
    logic                last_c;
    seq_desc_t           desc_c;

    logic                     req_q;
    logic                     pre_req_q;
    logic [IMGSIZE-1:0]       in_offset_q;
    logic [IMGSIZE-1:0]       out_offset_q;
    logic [GOBOU_NETSIZE-1:0] net_offset_q;
    logic [LWIDTH-1:0]        total_in_q;
    logic [LWIDTH-1:0]        total_out_q;
    logic [MEMSIZE-1:0]       pre_base_q;
    logic [LWIDTH-1:0]        read_len_q;
    logic [LWIDTH-1:0]        write_len_q;

    // Writes are locked out for the whole run; the done cycle already has busy low.
    gobou_seq_desc u_desc (
        .clk    (clk),
        .xrst   (xrst),
        .we     (cfg_we),
        .lock   (busy),
        .wlayer (cfg_layer),
        .field  (cfg_field),
        .wdata  (cfg_wdata),
        .rlayer (layer_q),
        .rdata  (desc_c)
    );

    assign last_c = (CNTW'({1'b0, layer_q}) + CNTW'(1)) == n_eff_q;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (n_layer == '0) ? S_FIN : S_LOAD;
            S_LOAD:   state_d = S_PRE;
            S_PRE:    state_d = S_PRE_LO;
            S_PRE_LO: if (!bus.pre_ack) state_d = S_PRE_HI;
            S_PRE_HI: if (bus.pre_ack) state_d = S_RUN;
            S_RUN:    state_d = S_RUN_LO;
            S_RUN_LO: if (!bus.ack) state_d = S_RUN_HI;
            S_RUN_HI: if (bus.ack) state_d = S_NEXT;
            S_NEXT:   state_d = last_c ? S_FIN : S_LOAD;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath registers, all driven from the next-state decision.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            host_sel     <= 1'b1;
            layer_q      <= '0;
            n_eff_q      <= '0;
            req_q        <= 1'b0;
            pre_req_q    <= 1'b0;
            in_offset_q  <= '0;
            out_offset_q <= '0;
            net_offset_q <= '0;
            total_in_q   <= '0;
            total_out_q  <= '0;
            pre_base_q   <= '0;
            read_len_q   <= '0;
            write_len_q  <= '0;
        end else begin
            busy      <= (state_d != S_IDLE) && (state_d != S_FIN);
            done      <= (state_d == S_FIN);
            pre_req_q <= (state_d == S_PRE);
            req_q     <= (state_d == S_RUN);

            // Host loses memory at the first RUN and only regains it at FIN.
            if (state_d == S_RUN) begin
                host_sel <= 1'b0;
            end else if (state_d == S_FIN) begin
                host_sel <= 1'b1;
            end

            if (state_q == S_IDLE && start) begin
                n_eff_q <= (n_layer > CNTW'(MAXLAYER)) ? CNTW'(MAXLAYER) : n_layer;
                layer_q <= '0;
            end else if (state_q == S_NEXT && !last_c) begin
                layer_q <= layer_q + LAYERLOG'(1);
            end

            if (state_q == S_LOAD) begin
                in_offset_q  <= desc_c.in_offset;
                out_offset_q <= desc_c.out_offset;
                net_offset_q <= desc_c.net_offset;
                total_in_q   <= desc_c.total_in;
                total_out_q  <= desc_c.total_out;
                pre_base_q   <= desc_c.in_offset[IMGSIZE-1:RATELOG];
                read_len_q   <= desc_c.total_in;
                write_len_q  <= LWIDTH'(GOBOU_CORE);
            end
        end
    end

    assign cur_layer      = layer_q;
    assign bus.req        = req_q;
    assign bus.pre_req    = pre_req_q;
    assign bus.in_offset  = in_offset_q;
    assign bus.out_offset = out_offset_q;
    assign bus.net_offset = net_offset_q;
    assign bus.total_in   = total_in_q;
    assign bus.total_out  = total_out_q;
    assign bus.pre_base   = pre_base_q;
    assign bus.read_len   = read_len_q;
    assign bus.write_len  = write_len_q;

endmodule

// File: tb/tb_gobou_seq.sv
// Directed bench for gobou_seq: descriptor and run tables plus hand-written corner sequences.
module tb_gobou_seq;
    import gobou_seq_pkg::*;

    logic                clk = 1'b0;
    logic                xrst;
    logic                cfg_we;
    logic [LAYERLOG-1:0] cfg_layer;
    logic [2:0]          cfg_field;
    logic [31:0]         cfg_wdata;
    logic                start;
    logic [LAYERLOG:0]   n_layer;
    logic                busy;
    logic                done;
    logic [LAYERLOG-1:0] cur_layer;
    logic                host_sel;

    gobou_seq_if bus ();

    gobou_seq dut (
        .clk       (clk),
        .xrst      (xrst),
        .cfg_we    (cfg_we),
        .cfg_layer (cfg_layer),
        .cfg_field (cfg_field),
        .cfg_wdata (cfg_wdata),
        .start     (start),
        .n_layer   (n_layer),
        .busy      (busy),
        .done      (done),
        .cur_layer (cur_layer),
        .host_sel  (host_sel),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]              w_in, w_out, w_net, w_tin, w_tout;
        logic [IMGSIZE-1:0]       e_in, e_out;
        logic [GOBOU_NETSIZE-1:0] e_net;
        logic [LWIDTH-1:0]        e_tin, e_tout;
        logic [MEMSIZE-1:0]       e_base;
    } desc_vec_t;

    typedef struct {
        logic [LAYERLOG:0] n;
        int                exp_layers;
        int                lat;
    } run_vec_t;

    typedef struct {
        logic [LAYERLOG-1:0]      layer;
        logic [IMGSIZE-1:0]       in_o, out_o;
        logic [GOBOU_NETSIZE-1:0] net;
        logic [LWIDTH-1:0]        tin, tout, rlen, wlen;
        logic [MEMSIZE-1:0]       base;
        logic                     hs;
    } cap_t;

    desc_vec_t dtab [4];
    run_vec_t  rtab [4];

    int checks = 0;
    int errors = 0;
    int lat = 4;

    cap_t pre_q[$];
    cap_t req_q[$];
    int   done_cnt = 0;
    int   hs_bad = 0;
    logic in_run = 1'b0;
    int   pre_t = 0;
    int   run_t = 0;

    // Peer models: ready drops right after a request and returns lat cycles later.
    always @(negedge clk) begin
        if (!xrst) begin
            bus.pre_ack = 1'b1;
            bus.ack     = 1'b1;
            pre_t       = 0;
            run_t       = 0;
        end else begin
            if (bus.pre_req) begin
                bus.pre_ack = 1'b0;
                pre_t       = lat;
            end else if (pre_t > 0) begin
                pre_t = pre_t - 1;
                if (pre_t == 0) bus.pre_ack = 1'b1;
            end
            if (bus.req) begin
                bus.ack = 1'b0;
                run_t   = lat;
            end else if (run_t > 0) begin
                run_t = run_t - 1;
                if (run_t == 0) bus.ack = 1'b1;
            end
        end
    end

    // Monitor: capture bus state at every pre_req/req pulse, count done, watch ownership.
    always @(negedge clk) begin
        cap_t c;
        if (!xrst) begin
            in_run = 1'b0;
        end else begin
            c.layer = cur_layer;
            c.in_o  = bus.in_offset;
            c.out_o = bus.out_offset;
            c.net   = bus.net_offset;
            c.tin   = bus.total_in;
            c.tout  = bus.total_out;
            c.rlen  = bus.read_len;
            c.wlen  = bus.write_len;
            c.base  = bus.pre_base;
            c.hs    = host_sel;
            if (bus.pre_req) pre_q.push_back(c);
            if (bus.req) req_q.push_back(c);
            if (in_run && host_sel && !done) hs_bad++;
            if (bus.req) in_run = 1'b1;
            if (done) begin
                done_cnt++;
                in_run = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int l, input logic [2:0] f, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_layer = LAYERLOG'(l);
        cfg_field = f;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [LAYERLOG:0] n);
        start   = 1'b1;
        n_layer = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 64'(done), 64'(1));
    endtask

    task automatic check_layer(input int p, input int r, input int l);
        chk("pre_layer", 64'(pre_q[p].layer), 64'(l));
        chk("pre_base",  64'(pre_q[p].base),  64'(dtab[l].e_base));
        chk("read_len",  64'(pre_q[p].rlen),  64'(dtab[l].e_tin));
        chk("write_len", 64'(pre_q[p].wlen),  64'(GOBOU_CORE));
        chk("req_layer", 64'(req_q[r].layer), 64'(l));
        chk("in_offset", 64'(req_q[r].in_o),  64'(dtab[l].e_in));
        chk("out_offset",64'(req_q[r].out_o), 64'(dtab[l].e_out));
        chk("net_offset",64'(req_q[r].net),   64'(dtab[l].e_net));
        chk("total_in",  64'(req_q[r].tin),   64'(dtab[l].e_tin));
        chk("total_out", 64'(req_q[r].tout),  64'(dtab[l].e_tout));
        chk("req_host_sel", 64'(req_q[r].hs), 64'(0));
    endtask

    initial begin
        int p0, r0, d0, h0;

        // Entry 0 writes carry junk above the field widths to exercise truncation.
        dtab[0] = '{32'h0, 32'h0001_03E8, 32'h0, 32'hFFFF_F200, 32'h0000_1080,
                    16'd0, 16'd1000, 14'd0, 12'd512, 12'd128, 12'h000};
        dtab[1] = '{32'h1230, 32'd2000, 32'd300, 32'd100, 32'd10,
                    16'h1230, 16'd2000, 14'd300, 12'd100, 12'd10, 12'h123};
        dtab[2] = '{32'h4560, 32'd3000, 32'd700, 32'd64, 32'd32,
                    16'h4560, 16'd3000, 14'd700, 12'd64, 12'd32, 12'h456};
        dtab[3] = '{32'hABC0, 32'd4000, 32'h0000_45DC, 32'd256, 32'd16,
                    16'hABC0, 16'd4000, 14'd1500, 12'd256, 12'd16, 12'hABC};

        rtab[0] = '{3'd1, 1, 50};
        rtab[1] = '{3'd3, 3, 4};
        rtab[2] = '{3'd0, 0, 2};
        rtab[3] = '{3'd7, 4, 3};

        xrst = 1'b0; start = 1'b0; n_layer = '0;
        cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",      64'(busy),          64'(0));
        chk("rst_done",      64'(done),          64'(0));
        chk("rst_host_sel",  64'(host_sel),      64'(1));
        chk("rst_req",       64'(bus.req),       64'(0));
        chk("rst_pre_req",   64'(bus.pre_req),   64'(0));
        chk("rst_write_len", 64'(bus.write_len), 64'(0));
        xrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            cfg_write(i, SEQ_F_IN,   dtab[i].w_in);
            cfg_write(i, SEQ_F_OUT,  dtab[i].w_out);
            cfg_write(i, SEQ_F_NET,  dtab[i].w_net);
            cfg_write(i, SEQ_F_TIN,  dtab[i].w_tin);
            cfg_write(i, SEQ_F_TOUT, dtab[i].w_tout);
        end
        cfg_write(0, 3'd5, 32'hDEAD_BEEF);
        cfg_write(2, 3'd7, 32'h1234_5678);

        for (int r = 0; r < 4; r++) begin
            lat = rtab[r].lat;
            p0 = pre_q.size(); r0 = req_q.size(); d0 = done_cnt; h0 = hs_bad;
            pulse_start(rtab[r].n);
            wait_done(2000);
            repeat (3) @(negedge clk);
            chk("run_pre_cnt",  64'(pre_q.size() - p0), 64'(rtab[r].exp_layers));
            chk("run_req_cnt",  64'(req_q.size() - r0), 64'(rtab[r].exp_layers));
            chk("run_done_cnt", 64'(done_cnt - d0),     64'(1));
            chk("run_host_sel", 64'(hs_bad - h0),       64'(0));
            for (int l = 0; l < rtab[r].exp_layers; l++) begin
                if (p0 + l < pre_q.size() && r0 + l < req_q.size()) check_layer(p0 + l, r0 + l, l);
            end
        end

        // Cycle-accurate single layer: LOAD in cycle 1, outputs and pre_req in cycle 2.
        lat = 3;
        pulse_start(3'd1);
        chk("c1_busy",     64'(busy),        64'(1));
        chk("c1_pre_req",  64'(bus.pre_req), 64'(0));
        chk("c1_host_sel", 64'(host_sel),    64'(1));
        @(negedge clk);
        chk("c2_pre_req",  64'(bus.pre_req),  64'(1));
        chk("c2_pre_base", 64'(bus.pre_base), 64'(0));
        chk("c2_read_len", 64'(bus.read_len), 64'(512));
        chk("c2_tout",     64'(bus.total_out), 64'(128));
        wait_done(500);
        chk("fin_busy",     64'(busy),     64'(0));
        chk("fin_host_sel", 64'(host_sel), 64'(1));
        @(negedge clk);
        chk("done_width", 64'(done), 64'(0));

        // Zero layers: done in the very next cycle, one cycle wide.
        pulse_start(3'd0);
        chk("n0_done", 64'(done), 64'(1));
        chk("n0_busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("n0_done_width", 64'(done), 64'(0));

        // Mid-run config write and second start are both ignored.
        lat = 10;
        p0 = pre_q.size(); r0 = req_q.size(); d0 = done_cnt;
        pulse_start(3'd3);
        repeat (4) @(negedge clk);
        cfg_write(1, SEQ_F_IN, 32'd77);
        pulse_start(3'd3);
        wait_done(2000);
        repeat (30) @(negedge clk);
        chk("mid_done_cnt", 64'(done_cnt - d0),     64'(1));
        chk("mid_req_cnt",  64'(req_q.size() - r0), 64'(3));
        if (req_q.size() - r0 == 3) begin
            chk("mid_l1_base", 64'(pre_q[p0 + 1].base), 64'(12'h123));
            chk("mid_l1_in",   64'(req_q[r0 + 1].in_o), 64'(16'h1230));
        end

        // start in the done cycle is dropped; cfg write in the done cycle lands.
        lat = 2;
        pulse_start(3'd1);
        wait_done(500);
        start = 1'b1; n_layer = 3'd1;
        cfg_we = 1'b1; cfg_layer = '0; cfg_field = SEQ_F_TOUT; cfg_wdata = 32'd99;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        chk("done_cycle_start_busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("done_cycle_start_idle", 64'(busy), 64'(0));
        r0 = req_q.size(); d0 = done_cnt;
        pulse_start(3'd1);
        wait_done(500);
        repeat (2) @(negedge clk);
        chk("wr_in_done_cnt", 64'(done_cnt - d0), 64'(1));
        if (req_q.size() > r0) chk("wr_in_done_tout", 64'(req_q[r0].tout), 64'(99));

        // Reset while in RUN_HI aborts to reset values with no done.
        lat = 50;
        r0 = req_q.size();
        pulse_start(3'd1);
        for (int k = 0; k < 500 && bus.req !== 1'b1; k++) @(negedge clk);
        chk("rst_req_seen", 64'(bus.req), 64'(1));
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        xrst = 1'b0;
        #1;
        chk("ab_host_sel",  64'(host_sel),      64'(1));
        chk("ab_busy",      64'(busy),          64'(0));
        chk("ab_req",       64'(bus.req),       64'(0));
        chk("ab_in_offset", 64'(bus.in_offset), 64'(0));
        chk("ab_total_in",  64'(bus.total_in),  64'(0));
        chk("ab_pre_base",  64'(bus.pre_base),  64'(0));
        chk("ab_write_len", 64'(bus.write_len), 64'(0));
        chk("ab_cur_layer", 64'(cur_layer),     64'(0));
        @(negedge clk);
        xrst = 1'b1;
        repeat (5) @(negedge clk);
        chk("ab_no_done", 64'(done_cnt - d0), 64'(0));

        lat = 2;
        r0 = req_q.size(); d0 = done_cnt;
        pulse_start(3'd1);
        wait_done(500);
        repeat (2) @(negedge clk);
        chk("post_rst_done", 64'(done_cnt - d0),     64'(1));
        chk("post_rst_req",  64'(req_q.size() - r0), 64'(1));
        if (req_q.size() > r0) begin
            chk("post_rst_in",   64'(req_q[r0].in_o), 64'(0));
            chk("post_rst_tin",  64'(req_q[r0].tin),  64'(0));
            chk("post_rst_tout", 64'(req_q[r0].tout), 64'(0));
            chk("post_rst_wlen", 64'(req_q[r0].wlen), 64'(GOBOU_CORE));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
